// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pkg
//  Description : Shared types for the radix-4 Booth multiplier: FSM states
//                and Booth digit codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

  // Multiplier control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Radix-4 Booth digit; bit 2 marks a negative multiple
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd5,
    NEG2 = 3'd6
  } digit_t;

endpackage
`default_nettype wire

// File: rtl/booth_digit_recode.sv
`default_nettype none
// ============================================================================
//  Module      : booth_digit_recode
//  Description : Maps a multiplier triplet {b[2i+1], b[2i], b[2i-1]} onto a
//                radix-4 Booth digit in {-2, -1, 0, +1, +2}.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_digit_recode
  import booth_pkg::*;
(
  input  logic [2:0] i_triplet,
  output digit_t     o_digit
);

  // Standard radix-4 Booth recoding table
  always_comb begin
    o_digit = ZERO;
    case (i_triplet)
      3'b001, 3'b010: o_digit = POS1;
      3'b011:         o_digit = POS2;
      3'b100:         o_digit = NEG2;
      3'b101, 3'b110: o_digit = NEG1;
      default:        o_digit = ZERO;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/booth_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mul_seq
//  Description : Sequential radix-4 Booth multiplier, one digit per clock.
//                Signed/unsigned WIDTH x WIDTH -> 2*WIDTH product on hi/lo,
//                with an overflow flag for products that do not fit WIDTH.
//                Optional macro BOOTH_EARLY_TERM_EN: finish as soon as all
//                remaining Booth digits are zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ovf
);

  localparam int N     = WIDTH / 2 + 1;       // Booth digit count
  localparam int CNT_W = $clog2(N + 1);
  localparam int EW    = WIDTH + 2;           // extended operand width
  localparam int AW    = 2 * WIDTH + 4;       // accumulator width

  state_t             r_state;
  state_t             w_state_nxt;
  logic [EW-1:0]      r_a;        // extended multiplicand
  logic [EW:0]        r_b;        // extended multiplier, bit 0 holds b[-1]
  logic [AW-1:0]      r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sgn;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_ovf;

  digit_t             w_digit;
  logic [EW:0]        w_mul;
  logic [EW-1:0]      w_sum;
  logic [AW-1:0]      w_acc_shift;
  logic [AW-1:0]      w_prod;
  logic [EW:0]        w_b_shift;
  logic               w_last;
  logic               w_start_ok;
  logic               w_unused_bits;

  booth_digit_recode u_recode (
    .i_triplet (r_b[2:0]),
    .o_digit   (w_digit)
  );

  // Digit multiple of the extended multiplicand
  always_comb begin
    w_mul = '0;
    case (w_digit)
      POS1:    w_mul = {r_a[EW-1], r_a};
      POS2:    w_mul = {r_a, 1'b0};
      NEG1:    w_mul = -{r_a[EW-1], r_a};
      NEG2:    w_mul = -{r_a, 1'b0};
      default: w_mul = '0;
    endcase
  end

  // The running partial sum at the add point is bounded by 2*|a|, so the
  // upper accumulator field never overflows and truncating the sum is exact.
  assign w_sum       = r_acc[AW-1 -: EW] + w_mul[EW-1:0];
  assign w_acc_shift = $signed({w_sum, r_acc[EW-1:0]}) >>> 2;
  assign w_b_shift   = $signed(r_b) >>> 2;
  assign w_start_ok  = start & (r_state != RUN);

`ifdef BOOTH_EARLY_TERM_EN
  logic             w_early;
  logic [CNT_W-1:0] w_rem;
  // Remaining bits plus overlap all equal means every remaining digit is 0;
  // the skipped digits still owe their 2-bit shifts, applied here at once.
  assign w_early = (&w_b_shift) | ~(|w_b_shift);
  assign w_rem   = CNT_W'(N - 1) - r_cnt;
  assign w_last  = (r_cnt == CNT_W'(N - 1)) | w_early;
  assign w_prod  = $signed(w_acc_shift) >>> {w_rem, 1'b0};
`else
  assign w_last  = (r_cnt == CNT_W'(N - 1));
  assign w_prod  = w_acc_shift;
`endif

  assign w_unused_bits = ^{w_prod[AW-1:2*WIDTH], w_mul[EW]};

  // State register
  always_ff @(posedge clk) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = start ? RUN : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture and one Booth step per RUN cycle
  always_ff @(posedge clk) begin
    if (clr) begin
      r_sgn <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_start_ok) begin
      r_sgn <= is_signed;
      r_a   <= {{2{is_signed & a[WIDTH-1]}}, a};
      r_b   <= {{2{is_signed & b[WIDTH-1]}}, b, 1'b0};
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_acc <= w_acc_shift;
      r_b   <= w_b_shift;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Result registers, loaded only on the edge that enters DONE
  always_ff @(posedge clk) begin
    if (clr) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_ovf <= 1'b0;
    end else if ((r_state == RUN) && w_last) begin
      r_hi  <= w_prod[2*WIDTH-1:WIDTH];
      r_lo  <= w_prod[WIDTH-1:0];
      r_ovf <= r_sgn ? (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}})
                     : (w_prod[2*WIDTH-1:WIDTH] != '0);
    end
  end

  assign hi  = r_hi;
  assign lo  = r_lo;
  assign ovf = r_ovf;

endmodule
`default_nettype wire
